// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin valid/ready arbiter sharing one single-cycle ALU
//               between two requesters; holds each response until accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctrl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_err,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctrl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err,
    output logic [3:0]       alu_control,
    output logic [WIDTH-1:0] alu_in_1,
    output logic [WIDTH-1:0] alu_in_2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last;
    logic               r_rsp_id;
    logic [3:0]         r_ctrl;
    logic [WIDTH-1:0]   r_in_1;
    logic [WIDTH-1:0]   r_in_2;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_err;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_rsp_hs;
    logic               w_supported;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_last names the requester served most recently; it loses the next tie.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_rsp_hs    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt0 = req0_valid && (!req1_valid || r_last);
                w_gnt1 = req1_valid && (!req0_valid || !r_last);
                if (w_gnt0 || w_gnt1) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_hs = r_rsp_id ? rsp1_ready : rsp0_ready;
                if (w_rsp_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_supported = (r_ctrl == 4'b0000) || (r_ctrl == 4'b0001) ||
                         (r_ctrl == 4'b0010) || (r_ctrl == 4'b0110) ||
                         (r_ctrl == 4'b0111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_rsp_id <= 1'b0;
            r_ctrl   <= 4'b0000;
            r_in_1   <= '0;
            r_in_2   <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_last <= w_gnt1;
                r_ctrl <= w_gnt1 ? req1_ctrl : req0_ctrl;
                r_in_1 <= w_gnt1 ? req1_a    : req0_a;
                r_in_2 <= w_gnt1 ? req1_b    : req0_b;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_id <= r_last;
                r_result <= w_supported ? alu_result : '0;
                r_zero   <= w_supported ? alu_zero   : 1'b1;
                r_err    <= !w_supported;
            end
        end
    end

    // Readies are gated by rst_n so they drop the instant reset asserts.
    assign req0_ready  = w_gnt0 && rst_n;
    assign req1_ready  = w_gnt1 && rst_n;
    assign rsp0_valid  = (r_state == ST_RESP) && !r_rsp_id;
    assign rsp1_valid  = (r_state == ST_RESP) &&  r_rsp_id;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_zero   = r_zero;
    assign rsp1_zero   = r_zero;
    assign rsp0_err    = r_err;
    assign rsp1_err    = r_err;
    assign alu_control = r_ctrl;
    assign alu_in_1    = r_in_1;
    assign alu_in_2    = r_in_2;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with an ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]       req0_ctrl, req1_ctrl;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic             rsp0_zero, rsp0_err, rsp1_zero, rsp1_err;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_in_1, alu_in_2, alu_result;
    logic             alu_zero;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter #(.WIDTH(WIDTH)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_control(alu_control), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU model; unsupported codes give a nonzero junk value the arbiter must mask.
    always_comb begin
        case (alu_control)
            4'b0000: alu_result = alu_in_1 & alu_in_2;
            4'b0001: alu_result = alu_in_1 | alu_in_2;
            4'b0010: alu_result = alu_in_1 + alu_in_2;
            4'b0110: alu_result = alu_in_1 - alu_in_2;
            4'b0111: alu_result = {31'd0, alu_in_1 < alu_in_2};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a ready, checks who got it, then passes the handshake edge.
    task automatic handshake(input int exp_who, output int waits);
        logic g0, g1;
        g0 = 1'b0;
        g1 = 1'b0;
        waits = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            g0 = req0_ready;
            g1 = req1_ready;
            if (g0 && g1) chk("ready_exclusive", 32'(g0 && g1), 32'd0);
            if (g0 || g1) break;
            waits++;
            cyc();
        end
        chk("grant", g1 ? 32'd1 : (g0 ? 32'd0 : 32'd2), 32'(exp_who));
        cyc();
    endtask

    task automatic response(input int who, input logic [31:0] r, input logic z, input logic e);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_no_valid", 32'(rsp0_valid | rsp1_valid), 32'd0);
        cyc();
        chk("rsp_valid", 32'(who == 0 ? rsp0_valid : rsp1_valid), 32'd1);
        chk("rsp_other_valid", 32'(who == 0 ? rsp1_valid : rsp0_valid), 32'd0);
        chk("rsp_result", who == 0 ? rsp0_result : rsp1_result, r);
        chk("rsp_zero", 32'(who == 0 ? rsp0_zero : rsp1_zero), 32'(z));
        chk("rsp_err", 32'(who == 0 ? rsp0_err : rsp1_err), 32'(e));
        cyc();
        chk("rsp_done_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 32'd5; req0_b = 32'd7;
        req1_valid = 1'b0; req1_ctrl = 4'b0000; req1_a = '0;    req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp0_valid | rsp1_valid), 32'd0);
        chk("rst_alu_control", 32'(alu_control), 32'd0);
        chk("rst_alu_in_1", alu_in_1, 32'd0);
        chk("rst_rsp_result", rsp0_result, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Single op: req0 ADD 5+7
        handshake(0, w);
        chk("first_idle_ready", 32'(w), 32'd0);
        req0_valid = 1'b0;
        chk("alu_in_1_latched", alu_in_1, 32'd5);
        chk("alu_in_2_latched", alu_in_2, 32'd7);
        response(0, 32'd12, 1'b0, 1'b0);

        // Tie after reset: req0 SUB 9-9 first, then req1 OR
        do_reset();
        req0_valid = 1'b1; req0_ctrl = 4'b0110; req0_a = 32'd9;    req0_b = 32'd9;
        req1_valid = 1'b1; req1_ctrl = 4'b0001; req1_a = 32'hF0;   req1_b = 32'h0F;
        handshake(0, w);
        req0_valid = 1'b0;
        response(0, 32'd0, 1'b1, 1'b0);
        handshake(1, w);
        req1_valid = 1'b0;
        response(1, 32'hFF, 1'b0, 1'b0);

        // Round-robin with both valids held: 0,1,0,1,0,1 at 3-cycle spacing
        req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 32'd1;  req0_b = 32'd2;
        req1_valid = 1'b1; req1_ctrl = 4'b0110; req1_a = 32'd10; req1_b = 32'd4;
        for (int i = 0; i < 6; i++) begin
            handshake(i % 2, w);
            chk("rr_no_gap", 32'(w), 32'd0);
            response(i % 2, (i % 2 == 1) ? 32'd6 : 32'd3, 1'b0, 1'b0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure: req1 SLT 3<8 held 5 cycles while req0 waits
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_ctrl = 4'b0111; req1_a = 32'd3; req1_b = 32'd8;
        handshake(1, w);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_ctrl = 4'b0011; req0_a = 32'd1; req0_b = 32'd1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp1_valid), 32'd1);
            chk("bp_result", rsp1_result, 32'd1);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req0_ready", 32'(req0_ready), 32'd0);
            cyc();
        end
        rsp1_ready = 1'b1;
        cyc();
        chk("bp_accepted", 32'(rsp1_valid), 32'd0);

        // Unsupported code 0011 from the waiting req0
        handshake(0, w);
        req0_valid = 1'b0;
        chk("bad_alu_control", 32'(alu_control), 32'd3);
        response(0, 32'd0, 1'b1, 1'b1);

        // Async reset in the middle of EXEC
        req1_valid = 1'b1; req1_ctrl = 4'b0010; req1_a = 32'd2; req1_b = 32'd2;
        handshake(1, w);
        req1_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_alu_control", 32'(alu_control), 32'd0);
        chk("arst_alu_in_1", alu_in_1, 32'd0);
        chk("arst_alu_in_2", alu_in_2, 32'd0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("arst_no_rsp", 32'(rsp0_valid | rsp1_valid | busy), 32'd0);
        end
        req0_valid = 1'b1; req0_ctrl = 4'b0000; req0_a = 32'hFF; req0_b = 32'h0F;
        req1_valid = 1'b1; req1_ctrl = 4'b0010; req1_a = 32'd3;  req1_b = 32'd4;
        handshake(0, w);
        req0_valid = 1'b0;
        response(0, 32'h0F, 1'b0, 1'b0);
        handshake(1, w);
        req1_valid = 1'b0;
        response(1, 32'd7, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle ALU between two independent requesters, e.g. the main datapath and a branch-target/address helper, using valid/ready handshakes on both request and response sides. It grants round-robin and registers the winning operands onto the ALU ports. After one settle cycle it captures `result`/`zero` and holds the response until the owning requester accepts it. It sits between the requesters and the ALU, and is the only driver of the ALU's `control`, `in_1` and `in_2`.

## Interface
- `WIDTH`, 32: operand/result width; must match the ALU.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req0_ctrl` in 4: requester 0 ALU control code.
- `req0_a`, `req0_b` in WIDTH: requester 0 operands.
- `rsp0_valid` out 1: response for requester 0 available.
- `rsp0_ready` in 1: requester 0 takes the response.
- `rsp0_result` out WIDTH: ALU result.
- `rsp0_zero` out 1: ALU zero flag.
- `rsp0_err` out 1: unsupported control code.
- `req1_*`, `rsp1_*`: identical set for requester 1.
- `alu_control` out 4: to ALU `control`.
- `alu_in_1`, `alu_in_2` out WIDTH: to ALU operands.
- `alu_result` in WIDTH: from ALU `result`.
- `alu_zero` in 1: from ALU `zero`.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states and transitions:
  - IDLE: wait for a request; go to EXEC on a handshake.
  - EXEC: one ALU settle cycle; always go to RESP.
  - RESP: go to IDLE on `rspN_valid && rspN_ready` for the granted N.
- Arbitration in IDLE:
  - If exactly one `reqN_valid` is high, grant N.
  - If both are high, grant the requester not served last.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - The pointer updates only on a request handshake.
- `reqN_ready` is asserted only in IDLE and only for the granted N. It is combinational from the valids and state; no dependence on ready from valid.
- On handshake, the arbiter latches `reqN_ctrl`/`a`/`b` into registers that drive `alu_control`/`alu_in_1`/`alu_in_2`. These hold until the next handshake.
- Supported codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (unsigned compare).
  - For any other code the response is: result 0, zero 1, err 1.
  - The ALU ports still receive the latched values.
- EXEC end: capture `alu_result`/`alu_zero` (or the error values) into response registers. Also latch the grant id.
- RESP: only `rsp<grant>_valid` is high. Both responses share the same result/zero/err registers, so `rspX_result` shows the same value on both ports; consumers must qualify with valid.
- Response registers hold stable while valid is high and not accepted.
- Non-granted requesters may change or drop their request at any time without effect.
- A requester may present a new request while its own response is pending. It is not accepted until IDLE.

## Timing
- Reset value of every output (asynchronous, immediate on `rst_n` low):
  - Outputs forced to 0: `req*_ready`, `rsp*_valid`, `rsp*_result`, `rsp*_zero`, `rsp*_err`, `alu_control` (0000), `alu_in_1`, `alu_in_2`, `busy`.
  - Internal: state IDLE, pointer 1.
- Latency:
  - Handshake at edge T.
  - EXEC during cycle T..T+1.
  - `rspN_valid` high after edge T+1.
- Response acceptance:
  - With `rspN_ready` already high, the response is accepted at edge T+2.
  - IDLE is reached after T+2, and the next handshake can occur at edge T+3.
- Minimum issue interval is 3 cycles; throughput is one operation per 3 cycles.
- Backpressure: RESP persists indefinitely while `rspN_ready` is low. No timeout.
- Reset asserted mid-EXEC or mid-RESP: the in-flight operation is discarded, no response is produced, and `rst_n` release returns to IDLE with pointer 1.
- Simultaneous valids at the same edge: exactly one ready is asserted. The loser keeps valid and is granted at the next IDLE.

## Test plan
- Reset then single op: req0 ADD a=5 b=7.
  - `req0_ready`=1 in the first IDLE cycle.
  - `rsp0_valid` 2 cycles later with result 12, zero 0, err 0.
  - `rsp1_valid` stays 0.
- Tie: both valid in the same cycle, req0 SUB 9-9 and req1 OR 0xF0|0x0F.
  - req0 is served first: result 0, zero 1.
  - req1 is then served: result 0xFF.
  - Ready never asserts on both ports in one cycle.
- Round-robin fairness: both hold valid continuously for 6 ops.
  - Grants alternate 0,1,0,1,0,1.
  - Each op takes exactly 3 cycles with `rsp*_ready` held 1.
- Backpressure: req1 SLT a=3 b=8 with `rsp1_ready`=0 for 5 cycles.
  - `rsp1_valid`=1 with result 1, stable for all 5 cycles.
  - `busy`=1 and `req0_ready`=0 throughout.
  - Accepted on the first cycle ready=1.
- Unsupported code: req0 ctrl=0011 a=1 b=1 -> result 0, zero 1, err 1.
- Async reset mid-EXEC: assert `rst_n`=0 one cycle after a handshake.
  - All outputs go 0 without waiting for a clock edge.
  - No `rsp_valid` appears after release.
  - The next tie grants req0.
